// File: rtl/burst_memory_if.sv
// Command/data bus of burst_memory: single accesses, burst control and read return.
// The master drives commands and write beats; the memory returns read data and status.
interface burst_memory_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LEN_W  = 8
);
  logic                cs;
  logic                rd_wr;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] be;
  logic                burst_start;
  logic [LEN_W-1:0]    burst_len;
  logic                wvalid;
  logic                burst_abort;
  logic [DATA_W-1:0]   rdata;
  logic                rvalid;
  logic                busy;
  logic                done;

  modport master (
    output cs, rd_wr, addr, wdata, be, burst_start, burst_len, wvalid, burst_abort,
    input  rdata, rvalid, busy, done
  );

  modport slave (
    input  cs, rd_wr, addr, wdata, be, burst_start, burst_len, wvalid, burst_abort,
    output rdata, rvalid, busy, done
  );
endinterface

// File: rtl/burst_memory.sv
// Single-port synchronous RAM with byte enables, registered read and an
// auto-incrementing burst engine for up to 2**LEN_W consecutive words.
module burst_memory #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LEN_W  = 8
) (
  input logic           clk,
  input logic           rst,
  burst_memory_if.slave bus
);

  localparam int unsigned Depth    = 2 ** ADDR_W;
  localparam int unsigned NumBytes = DATA_W / 8;

  typedef enum logic [1:0] {StIdle, StBurstRd, StBurstWr} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  // Remaining beats minus one, so a full 2**LEN_W burst fits in LEN_W bits.
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q;
  logic                rvalid_q;
  logic                done_q, done_d;

  logic                mem_we;
  logic                mem_re;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem [Depth];

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    mem_addr = bus.addr;
    case (state_q)
      StIdle: begin
        if (bus.cs) begin
          if (bus.burst_start) begin
            ptr_d   = bus.addr;
            cnt_d   = bus.burst_len;
            state_d = bus.rd_wr ? StBurstWr : StBurstRd;
          end else if (bus.rd_wr) begin
            mem_we = 1'b1;
          end else begin
            mem_re = 1'b1;
          end
        end
      end
      StBurstRd: begin
        if (bus.burst_abort) begin
          state_d = StIdle;
        end else begin
          mem_re   = 1'b1;
          mem_addr = ptr_q;
          ptr_d    = ptr_q + ADDR_W'(1);
          cnt_d    = cnt_q - LEN_W'(1);
          if (cnt_q == '0) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      StBurstWr: begin
        if (bus.burst_abort) begin
          state_d = StIdle;
        end else if (bus.wvalid) begin
          mem_we   = 1'b1;
          mem_addr = ptr_q;
          ptr_d    = ptr_q + ADDR_W'(1);
          cnt_d    = cnt_q - LEN_W'(1);
          if (cnt_q == '0) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      rvalid_q <= mem_re;
      rdata_q  <= mem_re ? mem[mem_addr] : '0;
      done_q   <= done_d;
    end
  end

  // Storage is never reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (bus.be[i]) begin
          mem[mem_addr][8*i +: 8] <= bus.wdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign bus.busy   = (state_q != StIdle);
  assign bus.done   = done_q;

endmodule

// File: tb/tb_burst_memory.sv
// Directed self-checking bench for burst_memory (DATA_W=32, ADDR_W=8, LEN_W=8).
module tb_burst_memory;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  burst_memory_if #(.DATA_W(32), .ADDR_W(8), .LEN_W(8)) bus ();

  burst_memory #(.DATA_W(32), .ADDR_W(8), .LEN_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.cs          = 1'b0;
    bus.rd_wr       = 1'b0;
    bus.burst_start = 1'b0;
    bus.wvalid      = 1'b0;
    bus.burst_abort = 1'b0;
  endtask

  task automatic write1(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
    bus.cs = 1'b1; bus.rd_wr = 1'b1; bus.burst_start = 1'b0;
    bus.addr = a; bus.wdata = d; bus.be = b;
    step();
    idle();
  endtask

  task automatic read1(input string tag, input logic [7:0] a, input logic [31:0] exp);
    bus.cs = 1'b1; bus.rd_wr = 1'b0; bus.burst_start = 1'b0; bus.addr = a;
    step();
    idle();
    chk({tag, "_rvalid"}, {31'd0, bus.rvalid}, 32'd1);
    chk({tag, "_rdata"}, bus.rdata, exp);
  endtask

  task automatic start_burst(input logic wr, input logic [7:0] a, input logic [7:0] len);
    bus.cs = 1'b1; bus.burst_start = 1'b1; bus.rd_wr = wr;
    bus.addr = a; bus.burst_len = len;
    step();
    idle();
  endtask

  initial begin
    idle();
    bus.addr = '0; bus.wdata = '0; bus.be = '0; bus.burst_len = '0;
    step(); step();
    rst = 1'b0;
    chk("reset_rdata", bus.rdata, 32'h0);
    chk("reset_rvalid", {31'd0, bus.rvalid}, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);

    // Single write then read, rdata returns to zero afterwards.
    write1(8'h10, 32'h0000_00A5, 4'hF);
    read1("single", 8'h10, 32'h0000_00A5);
    step();
    chk("single_rvalid_low", {31'd0, bus.rvalid}, 32'd0);
    chk("single_rdata_zero", bus.rdata, 32'h0);

    // Byte-enable merge.
    write1(8'h30, 32'h1122_3344, 4'hF);
    write1(8'h30, 32'hAABB_CCDD, 4'b0101);
    read1("be_merge", 8'h30, 32'h11BB_33DD);

    // Write burst with a two-cycle stall after beat 2.
    start_burst(1'b1, 8'h20, 8'd3);
    chk("wb_busy_start", {31'd0, bus.busy}, 32'd1);
    bus.be = 4'hF; bus.wvalid = 1'b1; bus.wdata = 32'd1;
    step();
    bus.wdata = 32'd2;
    step();
    bus.wvalid = 1'b0;
    step();
    chk("wb_busy_stall1", {31'd0, bus.busy}, 32'd1);
    step();
    chk("wb_busy_stall2", {31'd0, bus.busy}, 32'd1);
    chk("wb_done_stall", {31'd0, bus.done}, 32'd0);
    bus.wvalid = 1'b1; bus.wdata = 32'd3;
    step();
    chk("wb_done_beat3", {31'd0, bus.done}, 32'd0);
    bus.wdata = 32'd4;
    step();
    bus.wvalid = 1'b0;
    chk("wb_done", {31'd0, bus.done}, 32'd1);
    chk("wb_busy_end", {31'd0, bus.busy}, 32'd0);
    chk("wb_no_rvalid", {31'd0, bus.rvalid}, 32'd0);
    step();
    chk("wb_done_once", {31'd0, bus.done}, 32'd0);
    read1("wb_m20", 8'h20, 32'd1);
    read1("wb_m21", 8'h21, 32'd2);
    read1("wb_m22", 8'h22, 32'd3);
    read1("wb_m23", 8'h23, 32'd4);

    // Read burst wrapping from 0xFE to 0x01.
    write1(8'hFE, 32'hCAFE_00FE, 4'hF);
    write1(8'hFF, 32'hCAFE_00FF, 4'hF);
    write1(8'h00, 32'hCAFE_0000, 4'hF);
    write1(8'h01, 32'hCAFE_0001, 4'hF);
    start_burst(1'b0, 8'hFE, 8'd3);
    chk("rb_busy_t1", {31'd0, bus.busy}, 32'd1);
    chk("rb_rvalid_t1", {31'd0, bus.rvalid}, 32'd0);
    step();
    chk("rb_rvalid_t2", {31'd0, bus.rvalid}, 32'd1);
    chk("rb_rdata_t2", bus.rdata, 32'hCAFE_00FE);
    step();
    chk("rb_rdata_t3", bus.rdata, 32'hCAFE_00FF);
    step();
    chk("rb_rdata_t4", bus.rdata, 32'hCAFE_0000);
    chk("rb_done_t4", {31'd0, bus.done}, 32'd0);
    step();
    chk("rb_rvalid_t5", {31'd0, bus.rvalid}, 32'd1);
    chk("rb_rdata_t5", bus.rdata, 32'hCAFE_0001);
    chk("rb_done_t5", {31'd0, bus.done}, 32'd1);
    chk("rb_busy_t5", {31'd0, bus.busy}, 32'd0);
    step();
    chk("rb_rvalid_t6", {31'd0, bus.rvalid}, 32'd0);
    chk("rb_done_t6", {31'd0, bus.done}, 32'd0);

    // Read burst len 7 aborted at T+3, then a single read at T+4.
    start_burst(1'b0, 8'h20, 8'd7);
    step();
    chk("ab_rdata_t2", bus.rdata, 32'd1);
    step();
    chk("ab_rvalid_t3", {31'd0, bus.rvalid}, 32'd1);
    chk("ab_rdata_t3", bus.rdata, 32'd2);
    bus.burst_abort = 1'b1;
    step();
    chk("ab_busy_t4", {31'd0, bus.busy}, 32'd0);
    chk("ab_rvalid_t4", {31'd0, bus.rvalid}, 32'd0);
    chk("ab_done_t4", {31'd0, bus.done}, 32'd0);
    bus.burst_abort = 1'b0;
    read1("ab_after", 8'h10, 32'h0000_00A5);
    chk("ab_done_t5", {31'd0, bus.done}, 32'd0);

    // Reset in the middle of a write burst after two accepted beats.
    for (int i = 0; i < 4; i++) write1(8'h40 + 8'(i), 32'h0000_00EE, 4'hF);
    start_burst(1'b1, 8'h40, 8'd3);
    bus.be = 4'hF; bus.wvalid = 1'b1; bus.wdata = 32'h51;
    step();
    bus.wdata = 32'h52;
    step();
    rst = 1'b1; bus.wdata = 32'h53;
    step();
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    rst = 1'b0; bus.wvalid = 1'b0;
    step();
    read1("rst_m40", 8'h40, 32'h51);
    read1("rst_m41", 8'h41, 32'h52);
    read1("rst_m42", 8'h42, 32'hEE);
    read1("rst_m43", 8'h43, 32'hEE);
    write1(8'h44, 32'h1234_5678, 4'hF);
    read1("rst_new", 8'h44, 32'h1234_5678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/burst_memory.md
Name: burst_memory

Overview:
- Parametrised single-port synchronous RAM; next generation of the team's 256x8 memory.
- Adds configurable width and depth, per-byte write enables, and a registered read with a valid strobe.
- Adds an auto-incrementing burst engine that reads or writes up to 2**LEN_W consecutive words from one command.
- Sits between the CPU datapath or DMA-style masters and on-chip storage.

Parameters:
DATA_W, 8, data word width in bits; must be a multiple of 8.
ADDR_W, 8, address width; depth is fixed at 2**ADDR_W words.
LEN_W, 8, burst length field width.

Ports:
clk  input  1  single clock; all state changes on its rising edge.
rst  input  1  reset, synchronous, active-high.
cs  input  1  chip select for single access or burst start.
rd_wr  input  1  1 = write, 0 = read (same sense as existing memory).
addr  input  ADDR_W  word address for a single access, or burst base address.
wdata  input  DATA_W  write data for single writes and burst write beats.
be  input  DATA_W/8  byte enables; bit i gates wdata[8i+7:8i].
burst_start  input  1  with cs=1 in IDLE: start a burst instead of a single access.
burst_len  input  LEN_W  number of beats minus 1; 0 means 1 beat.
wvalid  input  1  burst write beat present on wdata/be.
burst_abort  input  1  terminate the active burst.
rdata  output  DATA_W  registered read data; 0 whenever rvalid=0.
rvalid  output  1  rdata valid this cycle.
busy  output  1  burst in progress; cs and burst_start are ignored while high.
done  output  1  one-cycle pulse when a burst completes normally.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: rdata=0, rvalid=0, busy=0, done=0, FSM returns to IDLE, pointer and count cleared.
- Reset does not clear memory contents.
- A reset mid-burst takes effect on the next edge; words already written are retained.
- FSM states are IDLE, BURST_RD and BURST_WR.
- IDLE, cs=1, burst_start=0, rd_wr=1: write mem[addr] on that edge, only for bytes with be=1.
- IDLE, cs=1, burst_start=0, rd_wr=0: rdata=mem[addr] and rvalid=1 in the next cycle (latency 1).
- A read the cycle after a write to the same address returns the new data.
- IDLE, cs=1, burst_start=1: latch ptr=addr, remaining beats N=burst_len+1, and direction rd_wr.
  - Move to BURST_RD or BURST_WR; busy=1 from the next cycle.
  - No memory access occurs in the start cycle.
- BURST_RD issues one read per cycle with no stall: rdata=mem[ptr] next cycle, ptr++, remaining--.
  - For a start at cycle T: busy is high T+1..T+N; rvalid is high T+2..T+N+1; done pulses at T+N+1.
  - busy falls at T+N+1.
- BURST_WR: when wvalid=1, write mem[ptr] under be, ptr++, remaining--.
  - When wvalid=0: stall with no write and the pointer held.
  - The cycle after the last accepted beat: busy=0, done=1, state IDLE.
- Pointer arithmetic is modulo 2**ADDR_W: ptr=2**ADDR_W-1 wraps to 0 silently.
- burst_abort=1 while busy:
  - No beat is issued or written in the abort cycle.
  - State is IDLE and busy=0 next cycle; done is not asserted.
  - A read issued in the cycle before the abort still returns rvalid in the abort cycle.
- burst_abort in IDLE is ignored.
- While busy, cs, burst_start, addr and burst_len are ignored; wdata, be and wvalid are used only in BURST_WR.
- rvalid is never high in BURST_WR and is never asserted for writes.
- done and rvalid may be high in the same cycle (last read beat).
- A new command is accepted in the cycle where done=1, since the FSM is already in IDLE.

Test Plan:
- Single write 0xA5 to addr 0x10 with be=1, then read 0x10 -> rvalid=1 one cycle later, rdata=0xA5; rdata=0 otherwise.
- DATA_W=32: write 0x11223344, then write 0xAABBCCDD with be=4'b0101 -> read returns 0x11BB33DD.
- Write burst at base 0x20, burst_len=3, data 1,2,3,4, wvalid low for 2 cycles after beat 2.
  - Expect mem[0x20..0x23]=1,2,3,4; busy spans the stall; done pulses once after beat 4.
- Read burst at base 0xFE, burst_len=3 (ADDR_W=8):
  - Expect rvalid at T+2..T+5 returning mem[0xFE], mem[0xFF], mem[0x00], mem[0x01].
  - Expect done at T+5 and busy low at T+5.
- Read burst len 7; assert burst_abort at cycle T+3 -> exactly 2 rvalid beats (T+2, T+3), busy=0 at T+4, no done.
  - The cs=1 read issued at T+4 is serviced.
- Write burst len 3; assert rst after 2 accepted beats -> outputs zero next cycle, only 2 words modified, new single access works.
